// File: rtl/axi_pkg.sv
// Shared AXI definitions for the on-chip RAM responder: response codes and FSM state types.
package axi_pkg;

    localparam int AXI_ADDR_W = 29;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_t;

endpackage

// File: rtl/axi_ram_resp_mem.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
// A read of a word being written in the same cycle returns the old contents.
module axi_ram_resp_mem #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Output register holds its value while re is low, which keeps a stalled beat stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 INCR-burst slave backed by on-chip byte-enable RAM, standing in for the DDR3 controller.
// Build option AXI_RAM_RESP_STALL_EN: LFSR-driven random stalls on wready/rvalid.
//
// state   | meaning
// W_IDLE  | awready high, waiting for a write burst address
// W_DATA  | wready high, storing beats, tracking length errors
// W_RESP  | bvalid high until bready
// R_IDLE  | arready high, waiting for a read burst address
// R_FETCH | first word being read from RAM
// R_DATA  | rvalid high, next word pre-read on every accepted beat
module axi_ram_responder
    import axi_pkg::*;
#(
    parameter int AXI_WIDTH   = 256,
    parameter int MEM_DEPTH_W = 10,
    parameter int ID_W        = 4
) (
    input  logic                   ui_clk,
    input  logic                   ui_rst,

    input  logic [ID_W-1:0]        axi_awid,
    input  logic [AXI_ADDR_W-1:0]  axi_awaddr,
    input  logic [7:0]             axi_awlen,
    input  logic                   axi_awvalid,
    output logic                   axi_awready,

    input  logic [AXI_WIDTH-1:0]   axi_wdata,
    input  logic [AXI_WIDTH/8-1:0] axi_wstrb,
    input  logic                   axi_wlast,
    input  logic                   axi_wvalid,
    output logic                   axi_wready,

    output logic [ID_W-1:0]        axi_bid,
    output logic [1:0]             axi_bresp,
    output logic                   axi_bvalid,
    input  logic                   axi_bready,

    input  logic [ID_W-1:0]        axi_arid,
    input  logic [AXI_ADDR_W-1:0]  axi_araddr,
    input  logic [7:0]             axi_arlen,
    input  logic                   axi_arvalid,
    output logic                   axi_arready,

    output logic [ID_W-1:0]        axi_rid,
    output logic [AXI_WIDTH-1:0]   axi_rdata,
    output logic [1:0]             axi_rresp,
    output logic                   axi_rlast,
    output logic                   axi_rvalid,
    input  logic                   axi_rready
);

    localparam int STRB_W   = AXI_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);

    logic go;

`ifdef AXI_RAM_RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Low two bits both zero on about one cycle in four.
    assign go = |lfsr[1:0];
`else
    assign go = 1'b1;
`endif

    // ---------------- write path ----------------
    w_state_t               w_state;
    logic                   w_rdy;
    logic [MEM_DEPTH_W-1:0] w_idx;
    logic [7:0]             w_len;
    logic [7:0]             w_cnt;
    logic                   w_over;
    logic                   w_err;
    logic                   w_hs;
    logic                   mem_we;

    assign axi_wready = w_rdy & go;
    assign w_hs       = axi_wvalid & axi_wready;
    assign mem_we     = w_hs & ~w_over;

    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            w_state     <= W_IDLE;
            axi_awready <= 1'b0;
            w_rdy       <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_bresp   <= RESP_OKAY;
            axi_bid     <= '0;
            w_idx       <= '0;
            w_len       <= '0;
            w_cnt       <= '0;
            w_over      <= 1'b0;
            w_err       <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (axi_awvalid && axi_awready) begin
                        axi_awready <= 1'b0;
                        axi_bid     <= axi_awid;
                        w_idx       <= axi_awaddr[ADDR_LSB +: MEM_DEPTH_W];
                        w_len       <= axi_awlen;
                        w_cnt       <= '0;
                        w_over      <= 1'b0;
                        w_err       <= 1'b0;
                        w_rdy       <= 1'b1;
                        w_state     <= W_DATA;
                    end else begin
                        axi_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (!w_over) begin
                            w_idx <= w_idx + 1'b1;
                        end
                        if (axi_wlast) begin
                            w_rdy      <= 1'b0;
                            axi_bvalid <= 1'b1;
                            axi_bresp  <= (w_err || w_over || (w_cnt != w_len)) ? RESP_SLVERR
                                                                                : RESP_OKAY;
                            w_state    <= W_RESP;
                        end else begin
                            // Beats past awlen are dropped; the first of them flags the error.
                            if (w_over) begin
                                w_err <= 1'b1;
                            end
                            if (w_cnt == w_len) begin
                                w_over <= 1'b1;
                            end else begin
                                w_cnt <= w_cnt + 1'b1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        axi_bvalid  <= 1'b0;
                        axi_awready <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // ---------------- read path ----------------
    r_state_t               r_state;
    logic                   r_vld;
    logic [MEM_DEPTH_W-1:0] r_idx;
    logic [7:0]             r_len;
    logic [7:0]             r_cnt;
    logic                   r_hs;
    logic                   mem_re;

    assign axi_rvalid = r_vld & go;
    assign axi_rresp  = RESP_OKAY;
    assign r_hs       = axi_rvalid & axi_rready;
    assign mem_re     = (r_state == R_FETCH) | ((r_state == R_DATA) & r_hs & ~axi_rlast);

    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            r_state     <= R_IDLE;
            axi_arready <= 1'b0;
            r_vld       <= 1'b0;
            axi_rlast   <= 1'b0;
            axi_rid     <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (axi_arvalid && axi_arready) begin
                        axi_arready <= 1'b0;
                        axi_rid     <= axi_arid;
                        r_idx       <= axi_araddr[ADDR_LSB +: MEM_DEPTH_W];
                        r_len       <= axi_arlen;
                        r_state     <= R_FETCH;
                    end else begin
                        axi_arready <= 1'b1;
                    end
                end
                R_FETCH: begin
                    r_idx     <= r_idx + 1'b1;
                    r_cnt     <= '0;
                    r_vld     <= 1'b1;
                    axi_rlast <= (r_len == 8'd0);
                    r_state   <= R_DATA;
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (axi_rlast) begin
                            r_vld       <= 1'b0;
                            axi_rlast   <= 1'b0;
                            axi_arready <= 1'b1;
                            r_state     <= R_IDLE;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_cnt     <= r_cnt + 1'b1;
                            axi_rlast <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    axi_ram_resp_mem #(
        .DATA_W (AXI_WIDTH),
        .ADDR_W (MEM_DEPTH_W)
    ) u_mem (
        .clk   (ui_clk),
        .rst   (ui_rst),
        .we    (mem_we),
        .waddr (w_idx),
        .wstrb (axi_wstrb),
        .wdata (axi_wdata),
        .re    (mem_re),
        .raddr (r_idx),
        .rdata (axi_rdata)
    );

    // Only the word-index field of the byte addresses is decoded.
    logic unused_addr;
    assign unused_addr = ^{axi_awaddr, axi_araddr};

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed self-checking bench for axi_ram_responder (default build, no stalls).
module tb_axi_ram_responder;

    localparam int W  = 256;
    localparam int SW = W / 8;

    logic           ui_clk = 1'b0;
    logic           ui_rst = 1'b1;
    logic [3:0]     axi_awid = '0;
    logic [28:0]    axi_awaddr = '0;
    logic [7:0]     axi_awlen = '0;
    logic           axi_awvalid = 1'b0;
    logic           axi_awready;
    logic [W-1:0]   axi_wdata = '0;
    logic [SW-1:0]  axi_wstrb = '0;
    logic           axi_wlast = 1'b0;
    logic           axi_wvalid = 1'b0;
    logic           axi_wready;
    logic [3:0]     axi_bid;
    logic [1:0]     axi_bresp;
    logic           axi_bvalid;
    logic           axi_bready = 1'b0;
    logic [3:0]     axi_arid = '0;
    logic [28:0]    axi_araddr = '0;
    logic [7:0]     axi_arlen = '0;
    logic           axi_arvalid = 1'b0;
    logic           axi_arready;
    logic [3:0]     axi_rid;
    logic [W-1:0]   axi_rdata;
    logic [1:0]     axi_rresp;
    logic           axi_rlast;
    logic           axi_rvalid;
    logic           axi_rready = 1'b0;

    always #5 ui_clk = ~ui_clk;

    axi_ram_responder dut (
        .ui_clk      (ui_clk),
        .ui_rst      (ui_rst),
        .axi_awid    (axi_awid),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bid     (axi_bid),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_arid    (axi_arid),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rid     (axi_rid),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Driver stimulus and observations
    logic [W-1:0]  wdat [16];
    logic [SW-1:0] wstb [16];
    logic [W-1:0]  rd_obs [16];
    logic          rl_obs [16];
    int            drv_timeout;
    int            w_first_wait;
    int            b_lat;
    logic [1:0]    bresp_obs;
    logic [3:0]    bid_obs;
    logic          awready_after;
    int            nb;
    int            first_lat;
    int            last_cyc;
    int            rlast_cnt;
    int            stall_chg;
    logic [3:0]    rid_obs;

    task automatic do_write(input logic [3:0] id, input int word, input int len, input int nbeats);
        int cnt;
        @(posedge ui_clk); #1;
        axi_awid    = id;
        axi_awaddr  = 29'(word * SW);
        axi_awlen   = 8'(len);
        axi_awvalid = 1'b1;
        cnt = 0;
        @(negedge ui_clk);
        while (!axi_awready && cnt < 50) begin
            cnt++;
            @(negedge ui_clk);
        end
        if (cnt >= 50) drv_timeout++;
        @(posedge ui_clk); #1;
        axi_awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            axi_wdata  = wdat[b];
            axi_wstrb  = wstb[b];
            axi_wlast  = (b == nbeats - 1);
            axi_wvalid = 1'b1;
            cnt = 0;
            @(negedge ui_clk);
            while (!axi_wready && cnt < 50) begin
                cnt++;
                @(negedge ui_clk);
            end
            if (cnt >= 50) drv_timeout++;
            if (b == 0) w_first_wait = cnt;
            @(posedge ui_clk); #1;
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        axi_bready = 1'b1;
        b_lat = 0;
        @(negedge ui_clk);
        while (!axi_bvalid && b_lat < 50) begin
            b_lat++;
            @(negedge ui_clk);
        end
        if (b_lat >= 50) drv_timeout++;
        bresp_obs = axi_bresp;
        bid_obs   = axi_bid;
        @(posedge ui_clk); #1;
        axi_bready    = 1'b0;
        awready_after = axi_awready;
    endtask

    task automatic do_read(input logic [3:0] id, input int word, input int len, input bit toggle);
        int cnt;
        logic [W-1:0] held;
        bit held_vld;
        bit done;
        @(posedge ui_clk); #1;
        axi_arid    = id;
        axi_araddr  = 29'(word * SW);
        axi_arlen   = 8'(len);
        axi_arvalid = 1'b1;
        cnt = 0;
        @(negedge ui_clk);
        while (!axi_arready && cnt < 50) begin
            cnt++;
            @(negedge ui_clk);
        end
        if (cnt >= 50) drv_timeout++;
        @(posedge ui_clk); #1;
        axi_arvalid = 1'b0;
        nb = 0; first_lat = -1; rlast_cnt = 0; stall_chg = 0;
        held = '0; held_vld = 1'b0; done = 1'b0; cnt = 0;
        while (!done && cnt < 200) begin
            axi_rready = toggle ? cnt[0] : 1'b1;
            @(negedge ui_clk);
            if (axi_rvalid) begin
                if (first_lat < 0) first_lat = cnt;
                if (held_vld && axi_rdata !== held) stall_chg++;
                if (axi_rready) begin
                    if (nb < 16) begin
                        rd_obs[nb] = axi_rdata;
                        rl_obs[nb] = axi_rlast;
                    end
                    rid_obs = axi_rid;
                    if (axi_rlast) begin
                        rlast_cnt++;
                        done = 1'b1;
                    end
                    nb++;
                    held_vld = 1'b0;
                end else begin
                    held     = axi_rdata;
                    held_vld = 1'b1;
                end
            end
            cnt++;
            @(posedge ui_clk); #1;
        end
        if (!done) drv_timeout++;
        last_cyc   = cnt;
        axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got %b expected 000000",
                     {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast});
        end
        n_checks++;
        if ({axi_bresp, axi_rresp, axi_bid, axi_rid} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_resp_id: got %h expected 000", {axi_bresp, axi_rresp, axi_bid, axi_rid});
        end
        n_checks++;
        if (axi_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 0", axi_rdata);
        end
        repeat (3) @(posedge ui_clk);
        #1 ui_rst = 1'b0;
        @(posedge ui_clk); #1;
        n_checks++;
        if ({axi_awready, axi_arready} !== 2'b11) begin
            n_fail++;
            $display("FAIL idle_ready: got %b expected 11", {axi_awready, axi_arready});
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            wdat[i] = W'(i + 1);
            wstb[i] = '1;
        end
        do_write(4'h3, 0, 3, 4);
        n_checks++;
        if (bresp_obs !== 2'b00) begin n_fail++; $display("FAIL basic_bresp: got %b expected 00", bresp_obs); end
        n_checks++;
        if (bid_obs !== 4'h3) begin n_fail++; $display("FAIL basic_bid: got %h expected 3", bid_obs); end
        n_checks++;
        if (w_first_wait !== 0) begin n_fail++; $display("FAIL wready_latency: got %0d expected 0", w_first_wait); end
        n_checks++;
        if (b_lat !== 0) begin n_fail++; $display("FAIL bvalid_latency: got %0d expected 0", b_lat); end
        n_checks++;
        if (awready_after !== 1'b1) begin n_fail++; $display("FAIL awready_after_b: got %b expected 1", awready_after); end
        do_read(4'h5, 0, 3, 1'b0);
        n_checks++;
        if (nb !== 4) begin n_fail++; $display("FAIL basic_beats: got %0d expected 4", nb); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_obs[i] !== W'(i + 1) || rl_obs[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got %h last %b expected %h last %b",
                         i, rd_obs[i], rl_obs[i], W'(i + 1), (i == 3));
            end
        end
        n_checks++;
        if (rid_obs !== 4'h5) begin n_fail++; $display("FAIL basic_rid: got %h expected 5", rid_obs); end
        n_checks++;
        if (first_lat !== 1) begin n_fail++; $display("FAIL rvalid_latency: got %0d expected 1", first_lat); end
        n_checks++;
        if (last_cyc - first_lat !== 4) begin
            n_fail++;
            $display("FAIL read_throughput: got %0d cycles expected 4", last_cyc - first_lat);
        end
    endtask

    task automatic test_strobe();
        logic [W-1:0] exp_v;
        wdat[0] = '1;
        wstb[0] = '1;
        do_write(4'h1, 5, 0, 1);
        wdat[0] = '0;
        wstb[0] = 32'h0000_000F;
        do_write(4'h1, 5, 0, 1);
        n_checks++;
        if (bresp_obs !== 2'b00) begin n_fail++; $display("FAIL strobe_bresp: got %b expected 00", bresp_obs); end
        do_read(4'h1, 5, 0, 1'b0);
        exp_v = '1;
        exp_v[31:0] = 32'h0;
        n_checks++;
        if (rd_obs[0] !== exp_v || rl_obs[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL strobe_data: got %h last %b expected %h last 1", rd_obs[0], rl_obs[0], exp_v);
        end
    endtask

    task automatic test_early_wlast();
        wdat[0] = W'(32'h77);
        wdat[1] = W'(32'h78);
        wstb[0] = '1;
        wstb[1] = '1;
        do_write(4'h9, 30, 3, 2);
        n_checks++;
        if (bresp_obs !== 2'b10) begin n_fail++; $display("FAIL early_wlast_bresp: got %b expected 10", bresp_obs); end
        n_checks++;
        if (b_lat !== 0) begin n_fail++; $display("FAIL early_wlast_blat: got %0d expected 0", b_lat); end
        n_checks++;
        if (awready_after !== 1'b1) begin n_fail++; $display("FAIL early_wlast_idle: got %b expected 1", awready_after); end
    endtask

    task automatic test_extra_beats();
        wdat[0] = W'(32'h55);
        wstb[0] = '1;
        do_write(4'h2, 12, 0, 1);
        wdat[0] = W'(32'hA0);
        wdat[1] = W'(32'hB0);
        wdat[2] = W'(32'hC0);
        for (int i = 0; i < 3; i++) wstb[i] = '1;
        do_write(4'h2, 10, 1, 3);
        n_checks++;
        if (bresp_obs !== 2'b10) begin n_fail++; $display("FAIL extra_bresp: got %b expected 10", bresp_obs); end
        do_read(4'h2, 10, 2, 1'b0);
        n_checks++;
        if (rd_obs[0] !== W'(32'hA0) || rd_obs[1] !== W'(32'hB0) || rd_obs[2] !== W'(32'h55)) begin
            n_fail++;
            $display("FAIL extra_dropped: got %h %h %h expected a0 b0 55",
                     rd_obs[0][31:0], rd_obs[1][31:0], rd_obs[2][31:0]);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) begin
            wdat[i] = W'(32'h100 + i);
            wstb[i] = '1;
        end
        do_write(4'h4, 1022, 3, 4);
        n_checks++;
        if (bresp_obs !== 2'b00) begin n_fail++; $display("FAIL wrap_bresp: got %b expected 00", bresp_obs); end
        do_read(4'h4, 1022, 3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_obs[i] !== W'(32'h100 + i)) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: got %h expected %h", i, rd_obs[i][31:0], 32'h100 + i);
            end
        end
        do_read(4'h4, 0, 1, 1'b0);
        n_checks++;
        if (rd_obs[0] !== W'(32'h102) || rd_obs[1] !== W'(32'h103)) begin
            n_fail++;
            $display("FAIL wrap_word0: got %h %h expected 102 103", rd_obs[0][31:0], rd_obs[1][31:0]);
        end
    endtask

    task automatic test_rready_toggle();
        for (int i = 0; i < 8; i++) begin
            wdat[i] = W'(32'h200 + i);
            wstb[i] = '1;
        end
        do_write(4'h6, 20, 7, 8);
        do_read(4'h7, 20, 7, 1'b1);
        n_checks++;
        if (nb !== 8) begin n_fail++; $display("FAIL toggle_beats: got %0d expected 8", nb); end
        n_checks++;
        if (rlast_cnt !== 1 || rl_obs[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_rlast: got count %0d last %b expected 1 1", rlast_cnt, rl_obs[7]);
        end
        n_checks++;
        if (stall_chg !== 0) begin n_fail++; $display("FAIL toggle_hold: got %0d changes expected 0", stall_chg); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rd_obs[i] !== W'(32'h200 + i)) begin
                n_fail++;
                $display("FAIL toggle_beat%0d: got %h expected %h", i, rd_obs[i][31:0], 32'h200 + i);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int cnt;
        @(posedge ui_clk); #1;
        axi_arid    = 4'h2;
        axi_araddr  = 29'(20 * SW);
        axi_arlen   = 8'd7;
        axi_arvalid = 1'b1;
        axi_rready  = 1'b1;
        cnt = 0;
        @(negedge ui_clk);
        while (!axi_arready && cnt < 50) begin
            cnt++;
            @(negedge ui_clk);
        end
        n_checks++;
        if (cnt >= 50) begin n_fail++; $display("FAIL midrst_ar: got timeout expected arready"); end
        @(posedge ui_clk); #1;
        axi_arvalid = 1'b0;
        repeat (3) @(posedge ui_clk);
        #2;
        n_checks++;
        if (axi_rvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_active: got rvalid %b expected 1", axi_rvalid); end
        ui_rst = 1'b1;
        #1;
        n_checks++;
        if ({axi_rvalid, axi_rlast, axi_arready} !== 3'b000 || axi_rdata !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: got %b rdata %h expected 000 rdata 0",
                     {axi_rvalid, axi_rlast, axi_arready}, axi_rdata[31:0]);
        end
        repeat (2) @(posedge ui_clk);
        #1;
        ui_rst     = 1'b0;
        axi_rready = 1'b0;
        do_read(4'hB, 20, 7, 1'b0);
        n_checks++;
        if (nb !== 8 || rid_obs !== 4'hB) begin
            n_fail++;
            $display("FAIL midrst_reread: got %0d beats rid %h expected 8 beats rid b", nb, rid_obs);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rd_obs[i] !== W'(32'h200 + i)) begin
                n_fail++;
                $display("FAIL midrst_beat%0d: got %h expected %h", i, rd_obs[i][31:0], 32'h200 + i);
            end
        end
    endtask

    initial begin
        drv_timeout = 0;
        test_reset();
        test_basic();
        test_strobe();
        test_early_wlast();
        test_extra_beats();
        test_wrap();
        test_rready_toggle();
        test_reset_mid_read();
        n_checks++;
        if (drv_timeout !== 0) begin
            n_fail++;
            $display("FAIL handshake_timeouts: got %0d expected 0", drv_timeout);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
